// File: rtl/spi_codec_responder.sv
// spi_codec_responder: SPI mode-0 responder emulating the external ADC/DAC codec.
// Optional feature macro SPI_RESP_LOOPBACK_EN adds a loopback input that echoes the last dac_word on miso.
module spi_codec_responder #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [WORD_W-1:0] adc_sample,
  input  logic              adc_load,
`ifdef SPI_RESP_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [WORD_W-1:0] dac_word,
  output logic              dac_valid,
  output logic              frame_err,
  output logic              overrun
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
  logic sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
  logic [WORD_W-1:0] hold_q, hold_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, dac_word_q, dac_word_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic miso_q, miso_d, miso_oe_q, miso_oe_d, dac_valid_q, dac_valid_d;
  logic frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [WORD_W-1:0] load_src, rx_next;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign rx_next   = {rx_sr_q[WORD_W-2:0], mosi_s};

  // Frame source: loopback echoes the last word, else a same-cycle load bypasses hold.
`ifdef SPI_RESP_LOOPBACK_EN
  assign load_src = loopback ? dac_word_q : (adc_load ? adc_sample : hold_q);
`else
  assign load_src = adc_load ? adc_sample : hold_q;
`endif

  // Next-state and next-output logic for synchronisers, hold register and frame FSM.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
    hold_d      = adc_load ? adc_sample : hold_q;
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    dac_word_d  = dac_word_q;
    bit_cnt_d   = bit_cnt_q;
    miso_d      = miso_q;
    miso_oe_d   = miso_oe_q;
    overrun_d   = overrun_q;
    dac_valid_d = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
        if (cs_fall) begin
          state_d   = SHIFT;
          tx_sr_d   = load_src;
          bit_cnt_d = '0;
          overrun_d = 1'b0;
          miso_oe_d = 1'b1;
          miso_d    = load_src[WORD_W-1];
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // cs rise takes priority over any sclk edge seen on the same cycle.
        if (cs_rise) begin
          state_d     = IDLE;
          frame_err_d = (bit_cnt_q != '0);
          miso_d      = 1'b0;
          miso_oe_d   = 1'b0;
        end else if (sclk_rise) begin
          rx_sr_d   = rx_next;
          bit_cnt_d = bit_cnt_q + CNT_ONE;
          if (bit_cnt_q == CNT_LAST) begin
            dac_word_d  = rx_next;
            dac_valid_d = 1'b1;
            state_d     = DONE;
            miso_d      = 1'b0;
          end else begin
            state_d = SHIFT;
          end
        end else if (sclk_fall) begin
          tx_sr_d = tx_sr_q << 1;
          miso_d  = tx_sr_q[WORD_W-2];
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        miso_d = 1'b0;
        if (cs_rise) begin
          state_d   = IDLE;
          miso_oe_d = 1'b0;
        end else if (sclk_rise) begin
          overrun_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d   = IDLE;
        miso_d    = 1'b0;
        miso_oe_d = 1'b0;
      end
    endcase
  end

  // State registers; cs chain resets low so a frame already in progress after reset is never seen as a fall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      hold_q      <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      dac_word_q  <= '0;
      bit_cnt_q   <= '0;
      miso_q      <= 1'b0;
      miso_oe_q   <= 1'b0;
      dac_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
      hold_q      <= hold_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      dac_word_q  <= dac_word_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_q      <= miso_d;
      miso_oe_q   <= miso_oe_d;
      dac_valid_q <= dac_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign miso      = miso_q;
  assign miso_oe   = miso_oe_q;
  assign dac_word  = dac_word_q;
  assign dac_valid = dac_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_codec_responder.sv
// Bench for spi_codec_responder: directed and random SPI frames checked against a word-level model.
// Honours SPI_RESP_LOOPBACK_EN the same way as the design.
module tb_spi_codec_responder;
  localparam int W = 16;
  localparam int H = 8;  // clk cycles per sclk half-period

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic cs = 1'b1;
  logic mosi = 1'b0;
  logic adc_load = 1'b0;
  logic [W-1:0] adc_sample = 16'h0000;
`ifdef SPI_RESP_LOOPBACK_EN
  logic loopback = 1'b0;
`endif
  logic miso, miso_oe, dac_valid, frame_err, overrun;
  logic [W-1:0] dac_word;

  int total = 0;
  int bad = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  logic [15:0] m_hold = 16'h0000;
  logic [15:0] m_dac = 16'h0000;
  logic m_ovr = 1'b0;

  spi_codec_responder #(.WORD_W(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .adc_sample(adc_sample), .adc_load(adc_load),
`ifdef SPI_RESP_LOOPBACK_EN
    .loopback(loopback),
`endif
    .dac_word(dac_word), .dac_valid(dac_valid), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dac_valid === 1'b1) dv_cnt <= dv_cnt + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] tx_src();
`ifdef SPI_RESP_LOOPBACK_EN
    return loopback ? m_dac : m_hold;
`else
    return m_hold;
`endif
  endfunction

  task automatic load(input logic [15:0] v);
    adc_sample = v;
    adc_load = 1'b1;
    tick(1);
    adc_load = 1'b0;
    m_hold = v;
  endtask

  // act: 0 none, 1 adc_load of act_val before bit act_bit, 2 reset pulse before bit act_bit
  task automatic frame(input string tag, input int nbits, input logic [31:0] mosi_v,
                       input int act, input int act_bit, input logic [15:0] act_val);
    logic [15:0] tx;
    logic [31:0] got, exp;
    int dv0, fe0;
    tx = tx_src();
    got = 32'h0;
    exp = 32'h0;
    for (int i = 0; i < nbits; i++) exp[nbits-1-i] = (i < 16) ? tx[15-i] : 1'b0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    cs = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      if (act == 1 && i == act_bit) load(act_val);
      if (act == 2 && i == act_bit) begin
        rst_n = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        m_hold = 16'h0000;
        m_dac = 16'h0000;
        m_ovr = 1'b0;
        chk({tag, "_oe_after_rst"}, {31'h0, miso_oe}, 32'h0);
        chk({tag, "_dac_after_rst"}, {16'h0, dac_word}, 32'h0);
      end
      mosi = mosi_v[nbits-1-i];
      tick(H);
      got[nbits-1-i] = miso;
      sclk = 1'b1;
      tick(H);
      sclk = 1'b0;
    end
    tick(H);
    cs = 1'b1;
    tick(2 * H);
    if (act != 2) begin
      chk({tag, "_miso"}, got, exp);
      chk({tag, "_dac_valid_cnt"}, 32'(dv_cnt - dv0), (nbits >= 16) ? 32'd1 : 32'd0);
      chk({tag, "_frame_err_cnt"}, 32'(fe_cnt - fe0), (nbits > 0 && nbits < 16) ? 32'd1 : 32'd0);
      if (nbits >= 16) m_dac = 16'(mosi_v >> (nbits - 16));
      m_ovr = (nbits > 16);
    end else begin
      chk({tag, "_dac_valid_cnt"}, 32'(dv_cnt - dv0), 32'd0);
      chk({tag, "_frame_err_cnt"}, 32'(fe_cnt - fe0), 32'd0);
    end
    chk({tag, "_dac_word"}, {16'h0, dac_word}, {16'h0, m_dac});
    chk({tag, "_overrun"}, {31'h0, overrun}, {31'h0, m_ovr});
    chk({tag, "_oe_idle"}, {31'h0, miso_oe}, 32'h0);
  endtask

  initial begin
    int nb;
    logic [31:0] mv;
    tick(4);
    rst_n = 1'b1;
    tick(2);
    chk("rst_miso", {31'h0, miso}, 32'h0);
    chk("rst_miso_oe", {31'h0, miso_oe}, 32'h0);
    chk("rst_dac_word", {16'h0, dac_word}, 32'h0);
    chk("rst_dac_valid", {31'h0, dac_valid}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);

    load(16'hA5C3);
    frame("full", 16, 32'h1234, 0, 0, 16'h0);
    frame("short", 9, 32'h1A5, 0, 0, 16'h0);
    frame("beef", 16, 32'hBEEF, 0, 0, 16'h0);
    frame("long", 20, 32'hFFFF0, 0, 0, 16'h0);
    frame("zero_bits", 0, 32'h0, 0, 0, 16'h0);

    load(16'h8001);
    frame("midload", 16, 32'h6C31, 1, 5, 16'h0F0F);
    frame("after_load", 16, 32'h2468, 0, 0, 16'h0);

    frame("rst_mid", 16, 32'h9ABC, 2, 8, 16'h0);
    frame("post_rst", 16, 32'h5555, 0, 0, 16'h0);

    load(16'h1357);
`ifdef SPI_RESP_LOOPBACK_EN
    loopback = 1'b1;
`endif
    frame("lb1", 16, 32'hC0DE, 0, 0, 16'h0);
    frame("lb2", 16, 32'h7777, 0, 0, 16'h0);
`ifdef SPI_RESP_LOOPBACK_EN
    loopback = 1'b0;
`endif

    for (int k = 0; k < 8; k++) begin
      nb = int'($urandom_range(0, 20));
      mv = $urandom;
      if ($urandom_range(0, 1) == 1) load(16'($urandom));
      frame($sformatf("rnd%0d", k), nb, mv, 0, 0, 16'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
